// File: rtl/cory_axis_rd_arb.sv
// rtl/cory_axis_rd_arb.sv - two-to-one round-robin read arbiter for a single-outstanding AR/R slave
// Grant is held from the AR handshake through the last R beat; a beat counter flags misplaced last beats.
module cory_axis_rd_arb #(
    parameter int A = 32,
    parameter int D = 64,
    parameter int L = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_s0_ar_v,
    input  logic [A-1:0] i_s0_ar_a,
    input  logic [L-1:0] i_s0_ar_l,
    output logic         o_s0_ar_r,
    output logic         o_s0_r_v,
    output logic [D-1:0] o_s0_r_d,
    output logic         o_s0_r_l,
    input  logic         i_s0_r_r,
    input  logic         i_s1_ar_v,
    input  logic [A-1:0] i_s1_ar_a,
    input  logic [L-1:0] i_s1_ar_l,
    output logic         o_s1_ar_r,
    output logic         o_s1_r_v,
    output logic [D-1:0] o_s1_r_d,
    output logic         o_s1_r_l,
    input  logic         i_s1_r_r,
    output logic         o_m_ar_v,
    output logic [A-1:0] o_m_ar_a,
    output logic [L-1:0] o_m_ar_l,
    input  logic         i_m_ar_r,
    input  logic         i_m_r_v,
    input  logic [D-1:0] i_m_r_d,
    input  logic         i_m_r_l,
    output logic         o_m_r_r,
    output logic [1:0]   o_gnt,
    output logic         o_busy,
    output logic         o_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t       state_q, state_d;
    logic         gnt_q, gnt_d;    // 0 selects s0, 1 selects s1
    logic         last_q, last_d;  // requester that most recently completed a burst
    logic [L-1:0] cnt_q, cnt_d;
    logic         err_q, err_d;

    logic         sel_ar_v;
    logic         sel_r_r;

    assign sel_ar_v = gnt_q ? i_s1_ar_v : i_s0_ar_v;
    assign sel_r_r  = gnt_q ? i_s1_r_r  : i_s0_r_r;

    assign o_m_ar_a = gnt_q ? i_s1_ar_a : i_s0_ar_a;
    assign o_m_ar_l = gnt_q ? i_s1_ar_l : i_s0_ar_l;
    assign o_s0_r_d = i_m_r_d;
    assign o_s1_r_d = i_m_r_d;

    assign o_gnt  = (state_q == IDLE) ? 2'b00 : {gnt_q, ~gnt_q};
    assign o_busy = (state_q != IDLE);
    assign o_err  = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        o_m_ar_v  = 1'b0;
        o_s0_ar_r = 1'b0;
        o_s1_ar_r = 1'b0;
        o_s0_r_v  = 1'b0;
        o_s1_r_v  = 1'b0;
        o_s0_r_l  = 1'b0;
        o_s1_r_l  = 1'b0;
        o_m_r_r   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_s0_ar_v | i_s1_ar_v) begin
                    gnt_d   = (i_s0_ar_v & i_s1_ar_v) ? ~last_q : i_s1_ar_v;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                o_m_ar_v  = sel_ar_v;
                o_s0_ar_r = ~gnt_q & i_m_ar_r;
                o_s1_ar_r =  gnt_q & i_m_ar_r;
                if (!sel_ar_v) begin
                    state_d = IDLE;
                end else if (i_m_ar_r) begin
                    cnt_d   = o_m_ar_l;
                    state_d = DATA;
                end
            end
            DATA: begin
                o_m_r_r  = sel_r_r;
                o_s0_r_v = ~gnt_q & i_m_r_v;
                o_s1_r_v =  gnt_q & i_m_r_v;
                o_s0_r_l = ~gnt_q & i_m_r_l;
                o_s1_r_l =  gnt_q & i_m_r_l;
                if (i_m_r_v & sel_r_r) begin
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - L'(1);
                    if (i_m_r_l != (cnt_q == '0)) begin
                        err_d = 1'b1;
                    end
                    // The slave's last flag, not the counter, ends the burst.
                    if (i_m_r_l) begin
                        last_d  = gnt_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/cory_axis_rd_arb.md
# cory_axis_rd_arb

Two-to-one read-channel arbiter placed in front of a single-outstanding AXI-style read slave, such as the behavioural memory model. It shares that slave's AR/R channels between requesters s0 and s1 using round-robin priority. Each grant is held for one complete burst, from the AR handshake through the last R beat. A beat counter checks that the slave marks the last beat at the position the burst length implies.

## Interface
Parameters:
- A, 32, address width in bits
- D, 64, data width in bits
- L, 4, burst-length field width; the burst has len+1 beats

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- i_s0_ar_v / i_s1_ar_v  in  1  requester read-address valid
- i_s0_ar_a / i_s1_ar_a  in  A  requester byte address
- i_s0_ar_l / i_s1_ar_l  in  L  requester burst length minus one
- o_s0_ar_r / o_s1_ar_r  out  1  requester address ready
- o_s0_r_v / o_s1_r_v  out  1  requester read-data valid
- o_s0_r_d / o_s1_r_d  out  D  read data; i_m_r_d is broadcast to both
- o_s0_r_l / o_s1_r_l  out  1  last-beat flag
- i_s0_r_r / i_s1_r_r  in  1  requester data ready
- o_m_ar_v, o_m_ar_a[A], o_m_ar_l[L], i_m_ar_r  slave AR channel
- i_m_r_v, i_m_r_d[D], i_m_r_l, o_m_r_r  slave R channel
- o_gnt  out  2  one-hot current grant; 0 when idle
- o_busy  out  1  high whenever the state is not IDLE
- o_err  out  1  sticky flag for a last-beat mismatch

## Operation
State machine with three states: IDLE, ADDR, DATA.
- **IDLE**
  - If any i_sN_ar_v is high, register the grant and move to ADDR.
  - Priority: when both request, the requester not equal to `last` wins.
  - When only one requests, that requester wins.
- **ADDR**
  - o_m_ar_v, o_m_ar_a and o_m_ar_l follow the granted requester's inputs.
  - The granted requester's o_sN_ar_r equals i_m_ar_r. The other requester's ar_r is 0.
  - On the handshake (o_m_ar_v & i_m_ar_r): load cnt with the granted ar_l and move to DATA.
  - If the granted ar_v drops before the handshake: return to IDLE. `last` is not updated.
- **DATA**
  - The granted requester's o_sN_r_v equals i_m_r_v, and its o_sN_r_l equals i_m_r_l.
  - o_m_r_r equals the granted requester's i_sN_r_r.
  - The ungranted requester's r_v and r_l are 0. Both ar_r outputs are 0.
  - On each beat (i_m_r_v & o_m_r_r): cnt decrements, saturating at 0.
  - If on a beat i_m_r_l differs from (cnt==0): set o_err.
  - A beat with i_m_r_l=1 ends the burst: return to IDLE and set `last` to the granted requester.
- **Outputs in IDLE:** every valid and ready output is 0; o_gnt=0.
- **Widths:** cnt is L bits. Beats per burst = ar_l+1, so the maximum burst is 2^L beats.
- **Slave model:** the slave holds at most one transaction outstanding. The arbiter never issues a second AR before the last beat of the current burst.
- **Burst termination:** the burst ends on i_m_r_l, not on cnt. An early or missing last is reported through o_err and otherwise followed as the slave signals it.

## Timing
- Reset values: state=IDLE, last=s1 (so s0 has first priority), o_gnt=0, o_busy=0, o_err=0, cnt=0. All valid/ready outputs are 0.
- Reset mid-burst: return to IDLE on the next edge. The slave must be reset in the same cycle.
- Address latency:
  - A request seen in IDLE in cycle n drives o_m_ar_v in cycle n+1.
  - The earliest AR handshake is in cycle n+1.
  - The first R beat can complete in the cycle after the AR handshake.
- R-channel routing is combinational and adds no cycle of latency.
- Back-to-back bursts: after the last-beat cycle, one IDLE cycle precedes the next ADDR.
- A new request that arrives while a burst is in progress waits. It is arbitrated in the IDLE cycle after the burst ends.
- The ungranted requester's ar_r is never high, even for a single cycle.

## Test plan
- **Reset priority:** after reset, s0 and s1 request in the same cycle → s0 is granted first (o_gnt=01); its burst with ar_l=3 delivers exactly 4 beats; then s1 is granted (o_gnt=10).
- **Continuous contention:** both requesters hold requests for 8 bursts → grants alternate s0,s1,s0,…, with exactly one IDLE cycle between bursts.
- **Back-pressure:** s1 toggles i_s1_r_r every cycle during a 16-beat burst → o_m_r_r mirrors i_s1_r_r; no beat is lost or duplicated; the data matches memory contents at addresses a, a+8, … for D=64.
- **Abort in ADDR:** slave holds i_m_ar_r=0 and s0 drops ar_v while in ADDR → next cycle is IDLE, `last` unchanged, and s0 keeps priority against s1.
- **Last-beat check:** slave asserts i_m_r_l on beat 2 of a burst with ar_l=3 → o_err=1 and stays high; the arbiter returns to IDLE.
- **Reset mid-burst:** reset asserted in DATA → the next cycle shows o_busy=0, o_gnt=0, o_err=0, and all valid/ready outputs 0.
